// File: rtl/sipo_frame_buffer.sv
// Serial-in / parallel-out frame buffer. A fill bank collects NINPUTS words,
// then hands the complete frame to a registered shadow bank read by the consumer.
module sipo_frame_buffer #(
  parameter int IWIDTH  = 8,
  parameter int NINPUTS = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IWIDTH-1:0]                  in_data,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [IWIDTH-1:0]                  out_data [NINPUTS-1:0],
  output logic [$clog2(NINPUTS+1)-1:0]       fill_level
);

  localparam int PW = $clog2(NINPUTS);
  localparam int LW = $clog2(NINPUTS+1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NINPUTS-1);

  logic [IWIDTH-1:0] fill [NINPUTS-1:0];
  logic [PW-1:0]     ptr;
  logic              fill_full;

  logic accept;
  logic last_beat;
  logic shadow_free;
  logic direct_load;
  logic pending_load;

  always_comb begin
    in_ready     = !rst && !fill_full && !flush;
    accept       = in_valid && in_ready;
    last_beat    = accept && (ptr == PTR_LAST);
    shadow_free  = !out_valid || out_ready;
    direct_load  = last_beat && shadow_free;
    // a flush discards a parked frame rather than letting it through
    pending_load = fill_full && shadow_free && !flush;
    fill_level   = fill_full ? LW'(NINPUTS) : LW'(ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      fill_full <= 1'b0;
      for (int i = 0; i < NINPUTS; i++) fill[i] <= '0;
    end else if (flush) begin
      ptr       <= '0;
      fill_full <= 1'b0;
    end else begin
      if (accept) begin
        fill[ptr] <= in_data;
        ptr       <= last_beat ? '0 : ptr + 1'b1;
        if (last_beat && !shadow_free) fill_full <= 1'b1;
      end
      if (pending_load) fill_full <= 1'b0;
    end
  end

  // The last word bypasses the fill bank so a frame can move with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      for (int i = 0; i < NINPUTS; i++) out_data[i] <= '0;
    end else if (direct_load) begin
      for (int i = 0; i < NINPUTS-1; i++) out_data[i] <= fill[i];
      out_data[NINPUTS-1] <= in_data;
      out_valid           <= 1'b1;
    end else if (pending_load) begin
      for (int i = 0; i < NINPUTS; i++) out_data[i] <= fill[i];
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame_buffer.sv
// Bench for sipo_frame_buffer: directed steps plus a gapped random phase,
// checked each cycle against a queue-based model of the frame buffer.
module tb_sipo_frame_buffer;
  localparam int IW = 8;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_data [N-1:0];
  logic [2:0]    fill_level;

  sipo_frame_buffer #(.IWIDTH(IW), .NINPUTS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: words gathered so far, and the frame on display
  logic [IW-1:0] fq [$];
  logic [IW-1:0] mframe [N];
  bit            mv;
  bit            m_acc;
  bit            rnd_on = 1'b0;
  int            rnd_base = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    mv = 1'b0;
    for (int i = 0; i < N; i++) mframe[i] = '0;
  endtask

  task automatic model_step();
    bit free;
    m_acc = in_valid && !flush && (fq.size() < N);
    free  = !mv || out_ready;
    if (flush) fq.delete();
    else if (m_acc) fq.push_back(in_data);
    if (!flush && fq.size() == N && free) begin
      for (int i = 0; i < N; i++) mframe[i] = fq[i];
      fq.delete();
      mv = 1'b1;
    end else if (out_ready) begin
      mv = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, 32'(!flush && fq.size() < N));
    chk("out_valid", out_valid, 32'(mv));
    chk("fill_level", fill_level, 32'(fq.size()));
    for (int i = 0; i < N; i++) chk($sformatf("out_data[%0d]", i), out_data[i], mframe[i]);
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (rnd_on && out_valid && out_ready) begin
      for (int i = 0; i < N; i++) chk("rnd_frame", out_data[i], 32'(rnd_base + i));
      rnd_base += N;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [IW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int next;
    // 1: reset applied between edges clears outputs at once
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fill_level", fill_level, 0);
    chk("rst_in_ready", in_ready, 0);
    for (int i = 0; i < N; i++) chk("rst_out_data", out_data[i], 0);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_in_ready", in_ready, 1);

    // 2: back-to-back frame, 1-cycle latency
    out_ready = 1'b1;
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk("t2_latency", out_valid, 1);
    chk("t2_d0", out_data[0], 8'hAA);
    chk("t2_d3", out_data[3], 8'hDD);
    cycle();

    // 3: backpressure parks the second frame in the fill bank
    out_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    chk("t3_fill_level", fill_level, 4);
    chk("t3_in_ready", in_ready, 0);
    chk("t3_hold_d0", out_data[0], 8'h11);
    cycle();
    chk("t3_still_held", out_data[3], 8'h44);
    out_ready = 1'b1;
    cycle();
    chk("t3_swap_valid", out_valid, 1);
    chk("t3_swap_d0", out_data[0], 8'h55);
    chk("t3_swap_d3", out_data[3], 8'h88);
    chk("t3_ready_back", in_ready, 1);
    cycle();

    // 4: flush discards a partial frame and blocks the beat that coincides
    send(8'hAA); send(8'hBB);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hCC;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_flush_level", fill_level, 0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t4_d0", out_data[0], 8'h01);
    chk("t4_d1", out_data[1], 8'h02);
    chk("t4_d3", out_data[3], 8'h04);
    cycle();
    cycle();

    // 5: gapped random traffic, three frames of 0x00..0x0B
    rnd_on = 1'b1;
    next = 0;
    for (int c = 0; c < 400 && next < 3*N; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = IW'(next);
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (m_acc) next++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    chk("rnd_sent", next, 3*N);
    chk("rnd_frames", rnd_base, 3*N);
    rnd_on = 1'b0;

    // 6: async reset mid-frame, then a clean frame
    send(8'hA1); send(8'hA2);
    #2 rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_fill_level", fill_level, 0);
    chk("t6_in_ready", in_ready, 0);
    for (int i = 0; i < N; i++) chk("t6_out_data", out_data[i], 0);
    model_reset();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    chk("t6_valid", out_valid, 1);
    chk("t6_d0", out_data[0], 8'hC1);
    chk("t6_d2", out_data[2], 8'hC3);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
